// File: rtl/scc_wave_sequencer.sv
// scc_wave_sequencer: five-channel SCC wavetable sequencer mixing over one shared wave RAM
module scc_wave_sequencer #(
    parameter int MIX_DIV  = 2,
    parameter int FREQ_MIN = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    input  logic [59:0]        freq,
    input  logic [19:0]        vol,
    input  logic [4:0]         enable,
    input  logic               scc_plus,
    input  logic               cpu_req,
    input  logic               cpu_wr,
    input  logic [7:0]         cpu_addr,
    input  logic [7:0]         cpu_wdata,
    output logic               cpu_ack,
    output logic [7:0]         cpu_rdata,
    output logic [7:0]         ram_addr,
    output logic               ram_we,
    output logic [7:0]         ram_wdata,
    input  logic [7:0]         ram_rdata,
    output logic signed [15:0] sound,
    output logic               sample_valid
);
    localparam logic [2:0] IDLE = 3'd0, F0 = 3'd1, F1 = 3'd2, F4 = 3'd5, LAST = 3'd6;
    localparam logic [11:0] FMIN = 12'(FREQ_MIN);
    localparam logic [3:0] DLAST = 4'(MIX_DIV - 1);

    logic [2:0] state, fi, ci, page;
    logic [3:0] div, v;
    logic pend, rd_now, fetch, slot, in_range, grant, wrap;
    logic [11:0] cnt [5];
    logic [4:0] phase [5];
    logic [7:0] hold;
    logic signed [11:0] smp, gain, prod;
    logic signed [14:0] acc, acc_next;

    // Fk fetches channel k; the data lands one cycle later, so F1..LAST consume channel state-F1
    always_comb begin
        fetch = state >= F0 && state <= F4;
        fi = fetch ? state - F0 : 3'd0;
        ci = state >= F1 ? state - F1 : 3'd0;
        page = (fi == 3'd4 && !scc_plus) ? 3'd3 : fi;
        in_range = cpu_addr < 8'd160;
        slot = state == IDLE || state == LAST;
        grant = reset_n && cpu_req && !cpu_ack && slot;
        wrap = ce && div == DLAST;
        v = vol[4*ci +: 4];
        smp = {{4{ram_rdata[7]}}, ram_rdata};
        gain = {8'd0, v};
        prod = enable[ci] ? smp * gain : 12'sd0;
        acc_next = acc + {{3{prod[11]}}, prod};
        ram_addr = fetch ? {page, phase[fi]} : (grant && in_range ? cpu_addr : 8'd0);
        ram_we = grant && cpu_wr && in_range;
        ram_wdata = grant ? cpu_wdata : 8'd0;
        cpu_rdata = rd_now ? ram_rdata : hold;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= '0;
                phase[i] <= '0;
            end
        end else if (ce) begin
            for (int i = 0; i < 5; i++)
                if (freq[12*i +: 12] >= FMIN) begin
                    cnt[i] <= cnt[i] == 12'd0 ? freq[12*i +: 12] : cnt[i] - 12'd1;
                    phase[i] <= cnt[i] == 12'd0 ? phase[i] + 5'd1 : phase[i];
                end
        end
    end

    // a CPU grant on the round-start cycle wins; pend carries the start one cycle later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            div <= '0;
            pend <= 1'b0;
            acc <= '0;
            sound <= '0;
            sample_valid <= 1'b0;
            cpu_ack <= 1'b0;
            rd_now <= 1'b0;
            hold <= 8'hFF;
        end else begin
            if (ce) div <= wrap ? 4'd0 : div + 4'd1;
            sample_valid <= state == LAST;
            cpu_ack <= grant;
            rd_now <= grant && !cpu_wr && in_range;
            if (grant && !in_range) hold <= 8'hFF;
            if (rd_now) hold <= ram_rdata;
            if (state == LAST) sound <= {acc_next, 1'b0};
            acc <= state == F0 ? 15'sd0 : acc_next;
            if (state == IDLE) begin
                pend <= (wrap || pend) && grant;
                state <= (wrap || pend) && !grant ? F0 : IDLE;
            end else begin
                state <= state == LAST ? IDLE : state + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_scc_wave_sequencer.sv
// tb_scc_wave_sequencer: randomized and directed checks against a ce-count based phase/mix model
module tb_scc_wave_sequencer;
    localparam int MD = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ce = 1'b0;
    logic [59:0] freq;
    logic [19:0] vol;
    logic [4:0] enable;
    logic scc_plus, cpu_req, cpu_wr, cpu_ack, ram_we, sample_valid, load;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata, ram_addr, ram_wdata, ram_rdata;
    logic signed [15:0] sound;
    logic [7:0] mem [256];
    logic [7:0] shadow [256];
    int checks = 0, errors = 0, cyc = 0, n_ce = 0, tie = 0;
    int ce_q[$], rnd_q[$];

    always #5 clk = ~clk;

    scc_wave_sequencer #(.MIX_DIV(MD), .FREQ_MIN(9)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .freq(freq), .vol(vol), .enable(enable),
        .scc_plus(scc_plus), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .sound(sound),
        .sample_valid(sample_valid)
    );

    always_ff @(posedge clk) begin
        if (load) for (int i = 0; i < 256; i++) mem[i] <= shadow[i];
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required finish before 2 ms");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // phase = advances seen after n ce pulses since reset: first ce advances, then every freq+1
    function automatic int model(input int s);
        int sum, n, f, ph, base;
        byte d;
        sum = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            foreach (ce_q[j]) if (ce_q[j] < s + k) n++;
            f = int'(freq[12*k +: 12]);
            ph = f < 9 ? 0 : ((n + f) / (f + 1)) % 32;
            base = k < 4 ? 32 * k : (scc_plus ? 128 : 96);
            d = shadow[base + ph];
            if (enable[k]) sum += int'(d) * int'(vol[4*k +: 4]);
        end
        return 2 * sum;
    endfunction

    task automatic step();
        if (ce) begin
            ce_q.push_back(cyc);
            n_ce++;
            if (n_ce % MD == 0) rnd_q.push_back(cyc + 1 + tie);
        end
        tie = 0;
        @(posedge clk);
        #1;
        cyc++;
        ce = 1'b0;
        if (rnd_q.size() > 0 && rnd_q[0] + 6 == cyc) begin
            chk("valid", sample_valid, 1);
            chk("sound", sound, model(rnd_q[0]));
            void'(rnd_q.pop_front());
        end else begin
            chk("novalid", sample_valid, 0);
        end
    endtask

    task automatic run_ce(input int n, input int lo, input int hi);
        for (int i = 0; i < n; i++) begin
            ce = 1'b1;
            step();
            repeat ($urandom_range(lo, hi) - 1) step();
        end
    endtask

    task automatic pre_trigger();
        while (n_ce % MD != MD - 1) run_ce(1, 8, 8);
    endtask

    task automatic chk_rst();
        chk("rst_sound", sound, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_rdata", cpu_rdata, 8'hFF);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
    endtask

    task automatic clear_model();
        ce_q.delete();
        rnd_q.delete();
        n_ce = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ce = 1'b0;
        cpu_req = 1'b0;
        load = 1'b1;
        clear_model();
        step();
        load = 1'b0;
        step();
        chk_rst();
        reset_n = 1'b1;
        step();
    endtask

    task automatic cpu_op(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat, output logic we0);
        cpu_req = 1'b1;
        cpu_wr = wr;
        cpu_addr = a;
        cpu_wdata = d;
        #1;
        we0 = ram_we;
        lat = 0;
        while (cpu_ack !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        rd = cpu_rdata;
        cpu_req = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] rd;
        logic we0;
        int lat;
        freq = '0;
        vol = '0;
        enable = '0;
        scc_plus = 1'b0;
        cpu_req = 1'b0;
        cpu_wr = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        load = 1'b0;
        for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
        do_reset();

        for (int i = 0; i < 32; i++) shadow[i] = 8'h40;
        freq[11:0] = 12'd100;
        vol[3:0] = 4'd15;
        enable = 5'b00001;
        do_reset();
        run_ce(10, 8, 8);
        chk("ch0_const", sound, 1920);

        for (int i = 0; i < 32; i++) shadow[i] = 8'(i);
        vol[3:0] = 4'd1;
        freq[11:0] = 12'd9;
        do_reset();
        run_ce(330, 8, 9);
        freq[11:0] = 12'd5;
        do_reset();
        run_ce(20, 8, 8);
        chk("freeze", sound, 0);

        for (int i = 0; i < 160; i++) shadow[i] = 8'h80;
        vol = 20'hFFFFF;
        enable = 5'b11111;
        scc_plus = 1'b1;
        do_reset();
        run_ce(4, 8, 8);
        chk("all_min", sound, -19200);
        enable = 5'b00000;
        run_ce(4, 8, 8);
        chk("all_off", sound, 0);

        for (int i = 96; i < 128; i++) shadow[i] = 8'h7F;
        for (int i = 128; i < 160; i++) shadow[i] = 8'h81;
        enable = 5'b10000;
        scc_plus = 1'b0;
        do_reset();
        run_ce(4, 8, 8);
        chk("ch4_shared", sound, 3810);
        scc_plus = 1'b1;
        run_ce(4, 8, 8);
        chk("ch4_own", sound, -3810);

        repeat (6) begin
            for (int i = 0; i < 160; i++) shadow[i] = 8'($urandom);
            for (int k = 0; k < 5; k++) freq[12*k +: 12] = 12'($urandom_range(0, 24));
            vol = 20'($urandom);
            enable = 5'($urandom);
            scc_plus = 1'($urandom);
            do_reset();
            run_ce(24, 8, 11);
        end

        pre_trigger();
        ce = 1'b1;
        step();
        step();
        step();
        #1;
        reset_n = 1'b0;
        #1;
        chk_rst();
        clear_model();
        step();
        step();
        reset_n = 1'b1;
        step();
        run_ce(6, 8, 8);

        pre_trigger();
        ce = 1'b1;
        step();
        cpu_req = 1'b1;
        cpu_wr = 1'b1;
        cpu_addr = 8'h10;
        cpu_wdata = 8'h55;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("we_slot", ram_we, i == 5);
            chk("ack_slot", cpu_ack, i == 6);
            if (cpu_ack) cpu_req = 1'b0;
            step();
        end
        shadow[16] = 8'h55;
        chk("mem_wr", mem[16], 8'h55);
        cpu_op(1'b0, 8'h10, 8'h00, rd, lat, we0);
        chk("rd_data", rd, 8'h55);
        chk("rd_lat", lat, 1);
        chk("rd_we", we0, 0);
        cpu_op(1'b0, 8'd200, 8'h00, rd, lat, we0);
        chk("oob_rd", rd, 8'hFF);
        chk("oob_lat", lat, 1);
        chk("oob_we", we0, 0);
        cpu_op(1'b1, 8'd200, 8'h33, rd, lat, we0);
        chk("oob_wr_lat", lat, 1);
        chk("oob_wr_we", we0, 0);
        chk("oob_wr_mem", mem[200], 8'h00);

        pre_trigger();
        ce = 1'b1;
        tie = 1;
        cpu_req = 1'b1;
        cpu_wr = 1'b0;
        cpu_addr = 8'h05;
        step();
        chk("tie_ack", cpu_ack, 1);
        chk("tie_rd", cpu_rdata, shadow[5]);
        cpu_req = 1'b0;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
